// File: rtl/demux32_deserializer.sv
// Serial-to-parallel deserializer: bit i of a word lands in w[i], double-buffered
// behind a valid/ready handshake. Optional w_par output under DEMUX_PARITY_EN.
module demux32_deserializer #(
  parameter int WIDTH = 32,
  parameter int SW    = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             d,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             flush,
  output logic [0:WIDTH-1] w,
  output logic             w_valid,
  input  logic             w_ready,
`ifdef DEMUX_PARITY_EN
  output logic             w_par,
`endif
  output logic [SW-1:0]    fill_cnt
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [SW-1:0] LAST = SW'(WIDTH-1);

  state_t           state;
  logic [0:WIDTH-1] fill;
  logic [0:WIDTH-1] w_next;
  logic             accept, last, hs, load_w;

  always_comb begin
    accept = d_valid && d_ready;
    last   = (fill_cnt == LAST);
    hs     = w_valid && w_ready;
    // In HOLD the fill register already carries the final bit; in FILL it arrives on d.
    w_next = fill;
    if (state == FILL) w_next[WIDTH-1] = d;
    load_w = !flush &&
             (((state == HOLD) && w_ready) ||
              ((state == FILL) && accept && last && (!w_valid || w_ready)));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= FILL;
      d_ready  <= 1'b1;
      fill     <= '0;
      fill_cnt <= '0;
      w        <= '0;
      w_valid  <= 1'b0;
    end else begin
      if (load_w) begin
        w       <= w_next;
        w_valid <= 1'b1;
      end else if (hs) begin
        w_valid <= 1'b0;
      end

      if (flush) begin
        // Flush drops the partial (or held) word; the output side is left alone.
        fill     <= '0;
        fill_cnt <= '0;
        state    <= FILL;
        d_ready  <= 1'b1;
      end else if (state == HOLD) begin
        if (w_ready) begin
          fill     <= '0;
          fill_cnt <= '0;
          state    <= FILL;
          d_ready  <= 1'b1;
        end
      end else if (accept) begin
        if (!last) begin
          fill[fill_cnt] <= d;
          fill_cnt       <= fill_cnt + SW'(1);
        end else if (load_w) begin
          fill     <= '0;
          fill_cnt <= '0;
        end else begin
          fill[WIDTH-1] <= d;
          state         <= HOLD;
          d_ready       <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     w_par <= 1'b0;
    else if (load_w) w_par <= ^w_next;
  end
`endif

endmodule
